// File: rtl/serial_sub20.sv
// Bit-serial two's-complement subtractor, Diff = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused WIDTH times under a start/busy/done handshake.
module serial_sub20 #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] rreg;
  logic             br;
  logic [CW-1:0]    count;

  logic             a0;
  logic             b0;
  logic             dbit;
  logic             br_next;
  logic             accept;
  logic             last_bit;

  assign a0       = areg[0];
  assign b0       = breg[0];
  assign dbit     = a0 ^ b0 ^ br;
  assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == SHIFT) && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == LAST) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand, borrow and partial-result shift registers; areg[0] holds A's MSB on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      areg  <= '0;
      breg  <= '0;
      rreg  <= '0;
      br    <= 1'b0;
      count <= '0;
    end else if (accept) begin
      areg  <= A;
      breg  <= B;
      rreg  <= '0;
      br    <= Bin;
      count <= '0;
    end else if (state == SHIFT) begin
      areg  <= areg >> 1;
      breg  <= breg >> 1;
      rreg  <= {dbit, rreg[WIDTH-1:1]};
      br    <= br_next;
      count <= count + 1'b1;
    end
  end

  // Visible results change only on the edge that completes the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Diff <= '0;
      Bout <= 1'b0;
      Ovf  <= 1'b0;
    end else if (last_bit) begin
      Diff <= {dbit, rreg[WIDTH-1:1]};
      Bout <= br_next;
      Ovf  <= (a0 != b0) && (dbit != a0);
    end
  end

endmodule

// File: tb/tb_serial_sub20.sv
// Directed self-checking bench for serial_sub20: arithmetic, flags, latency,
// ignored starts, back-to-back operation and asynchronous reset abort.
module tb_serial_sub20;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] A;
  logic [19:0] B;
  logic        Bin;
  logic        busy;
  logic        done;
  logic [19:0] Diff;
  logic        Bout;
  logic        Ovf;

  int assertions;
  int failures;
  int cyc;
  int doneCount;
  int firstDone;
  int secondDone;

  serial_sub20 #(.WIDTH(20)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout),
    .Ovf   (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
  endtask

  // Presents operands and pulses start for one edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [19:0] a, input logic [19:0] b, input logic bin);
    A     = a;
    B     = b;
    Bin   = bin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic runOp(input string tag, input logic [19:0] a, input logic [19:0] b, input logic bin,
                       input logic [19:0] expDiff, input logic expBout, input logic expOvf);
    int c;
    applyStimulus(a, b, bin);
    waitDone(c);
    checkOutput({tag, "_latency"}, c, 20);
    checkOutput({tag, "_diff"}, {12'd0, Diff}, {12'd0, expDiff});
    checkOutput({tag, "_bout"}, {31'd0, Bout}, {31'd0, expBout});
    checkOutput({tag, "_ovf"}, {31'd0, Ovf}, {31'd0, expOvf});
    @(posedge clk);
    #1;
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_done", {31'd0, done}, 0);
    checkOutput("reset_diff", {12'd0, Diff}, 0);
    checkOutput("reset_flags", {30'd0, Bout, Ovf}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic subtraction and busy/done handshake");
    applyStimulus(20'd150, 20'd50, 1'b0);
    checkOutput("t1_busy_after_start", {31'd0, busy}, 1);
    waitDone(cyc);
    checkOutput("t1_latency", cyc, 20);
    checkOutput("t1_busy_at_done", {31'd0, busy}, 0);
    checkOutput("t1_diff", {12'd0, Diff}, 100);
    checkOutput("t1_flags", {30'd0, Bout, Ovf}, 0);
    @(posedge clk);
    #1;
    checkOutput("t1_done_one_cycle", {31'd0, done}, 0);
    checkOutput("t1_diff_hold", {12'd0, Diff}, 100);

    runOp("t2_neg", 20'd50, 20'd150, 1'b0, 20'hFFF9C, 1'b1, 1'b0);
    runOp("t3_ovf_pos", 20'h7FFFF, 20'hFFFFF, 1'b0, 20'h80000, 1'b1, 1'b1);
    runOp("t3_ovf_neg", 20'h80000, 20'h00001, 1'b0, 20'h7FFFF, 1'b0, 1'b1);
    runOp("t4_bin_zero", 20'd0, 20'd0, 1'b1, 20'hFFFFF, 1'b1, 1'b0);
    runOp("t4_bin_small", 20'd5, 20'd2, 1'b1, 20'd2, 1'b0, 1'b0);

    $display("[TB] start during busy and operand changes mid-run");
    applyStimulus(20'd150, 20'd50, 1'b0);
    A = 20'd1;
    B = 20'd1;
    Bin = 1'b1;
    doneCount = 0;
    firstDone = 0;
    for (int i = 1; i <= 30; i++) begin
      start = (i == 5);
      @(posedge clk);
      #1;
      if (i > 1 && i < 20) begin
        if (Diff !== 20'd2) begin
          checkOutput("t5_diff_stable_while_busy", {12'd0, Diff}, 2);
        end
      end
      if (done) begin
        doneCount++;
        if (firstDone == 0) firstDone = i;
      end
    end
    start = 1'b0;
    checkOutput("t5_done_count", doneCount, 1);
    checkOutput("t5_done_cycle", firstDone, 20);
    checkOutput("t5_diff", {12'd0, Diff}, 100);

    $display("[TB] back-to-back with start held high");
    A = 20'd10;
    B = 20'd3;
    Bin = 1'b0;
    start = 1'b1;
    doneCount = 0;
    firstDone = 0;
    secondDone = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        doneCount++;
        if (doneCount == 1) firstDone = i;
        if (doneCount == 2) begin
          secondDone = i;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checkOutput("t5b_first_done", firstDone, 21);
    checkOutput("t5b_throughput", secondDone - firstDone, 22);
    checkOutput("t5b_diff", {12'd0, Diff}, 7);
    checkOutput("t5b_idle_after", {31'd0, busy}, 0);

    $display("[TB] asynchronous reset mid-operation");
    runOp("t6_pre", 20'h7FFFF, 20'hFFFFF, 1'b0, 20'h80000, 1'b1, 1'b1);
    applyStimulus(20'd300, 20'd100, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_busy_cleared", {31'd0, busy}, 0);
    checkOutput("t6_done_cleared", {31'd0, done}, 0);
    checkOutput("t6_diff_cleared", {12'd0, Diff}, 0);
    checkOutput("t6_flags_cleared", {30'd0, Bout, Ovf}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    doneCount = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("t6_no_done_after_abort", doneCount, 0);
    runOp("t6_restart", 20'd1000, 20'd1, 1'b0, 20'd999, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
